if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the SRAM-interface pipelined MIPS core.
- Generates the PC and drives the synchronous inst_sram port.
- Delivers {pc, instr, flags} to the decode stage, whose instr bus also feeds the debug instruction-name decoder.
- Handles downstream stall, branch/jump redirect, exception/ERET flush, delay-slot marking and fetch address-error detection.

---
 rtl/if_fetch_stage_pkg.sv | 41 ++++
 rtl/if_fetch_stage_if.sv | 21 ++
 rtl/if_fetch_stage_pc_mux.sv | 37 +++
 rtl/if_fetch_stage.sv | 98 +++++++++
 tb/tb_if_fetch_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/exception vectors,
// kseg address masks, next-PC select encoding and the decode-slot payload.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] EXC_VECTOR       = 32'hBFC0_0380;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  // kseg0/kseg1 window 0x8000_0000..0xBFFF_FFFF maps to physical by dropping [31:29]
  localparam logic [XLEN-1:0] KSEG_SEG_MASK    = 32'hC000_0000;
  localparam logic [XLEN-1:0] KSEG_SEG_BASE    = 32'h8000_0000;
  localparam logic [XLEN-1:0] KSEG_PHYS_MASK   = 32'h1FFF_FFFF;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_HOLD   = 2'd2,
    PC_FLUSH  = 2'd3
  } pc_sel_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            adel;
    logic            in_delayslot;
  } id_slot_t;

  function automatic logic [XLEN-1:0] kseg_map(input logic [XLEN-1:0] va, input bit map_en);
    if (map_en && ((va & KSEG_SEG_MASK) == KSEG_SEG_BASE)) begin
      return va & KSEG_PHYS_MASK;
    end
    return va;
  endfunction

  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Synchronous instruction-SRAM port; the fetch stage is the master.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic            inst_sram_en;
  logic [3:0]      inst_sram_wen;
  logic [XLEN-1:0] inst_sram_addr;
  logic [XLEN-1:0] inst_sram_wdata;
  logic [XLEN-1:0] inst_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata
  );

endinterface

// File: rtl/if_fetch_stage_pc_mux.sv
// Next-PC priority select: flush over stall over taken branch over sequential.
module fetch_pc_mux
  import if_fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] pc_f,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output pc_sel_e         sel_c,
  output logic [XLEN-1:0] next_pc_c
);

  always_comb begin
    sel_c = PC_SEQ;
    if (flush) begin
      sel_c = PC_FLUSH;
    end else if (stall) begin
      sel_c = PC_HOLD;
    end else if (branch_taken) begin
      sel_c = PC_BRANCH;
    end
  end

  // Sequential increment wraps naturally at 32 bits.
  always_comb begin
    next_pc_c = pc_f + PC_STEP;
    case (sel_c)
      PC_FLUSH:  next_pc_c = flush_pc;
      PC_HOLD:   next_pc_c = pc_f;
      PC_BRANCH: next_pc_c = branch_target;
      default:   next_pc_c = pc_f + PC_STEP;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC generation, inst_sram request, decode-slot
// registers with a one-entry hold buffer that covers decode stalls.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter bit              KSEG_MAP = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [XLEN-1:0]     flush_pc_i,
  input  logic                branch_taken_i,
  input  logic [XLEN-1:0]     branch_target_i,
  input  logic                id_is_branch_i,
  if_fetch_stage_if.master    sram,
  output logic                id_valid_o,
  output logic [XLEN-1:0]     id_pc_o,
  output logic [XLEN-1:0]     id_instr_o,
  output logic                id_adel_o,
  output logic                id_in_delayslot_o
);

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] next_pc_c;
  pc_sel_e         pc_sel_c;
  id_slot_t        slot;
  logic            hold_valid;
  logic [XLEN-1:0] hold_instr;

  fetch_pc_mux u_pc_mux (
    .pc_f          (pc_f),
    .flush         (flush_i),
    .flush_pc      (flush_pc_i),
    .stall         (stall_i),
    .branch_taken  (branch_taken_i),
    .branch_target (branch_target_i),
    .sel_c         (pc_sel_c),
    .next_pc_c     (next_pc_c)
  );

  // Request is gated by reset so nothing is issued while resetn is low.
  assign sram.inst_sram_en    = resetn & ~misaligned(pc_f);
  assign sram.inst_sram_addr  = kseg_map(pc_f, KSEG_MAP);
  assign sram.inst_sram_wen   = 4'b0000;
  assign sram.inst_sram_wdata = '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= next_pc_c;
    end
  end

  // Decode slot and hold buffer; a stall freezes the slot and latches rdata once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot       <= '0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
    end else begin
      case (pc_sel_c)
        PC_FLUSH: begin
          slot.valid        <= 1'b0;
          slot.adel         <= 1'b0;
          slot.in_delayslot <= 1'b0;
          hold_valid        <= 1'b0;
        end
        PC_HOLD: begin
          if (!hold_valid) begin
            hold_instr <= sram.inst_sram_rdata;
            hold_valid <= 1'b1;
          end
        end
        default: begin
          slot.valid        <= 1'b1;
          slot.pc           <= pc_f;
          slot.adel         <= misaligned(pc_f);
          slot.in_delayslot <= id_is_branch_i;
          hold_valid        <= 1'b0;
        end
      endcase
    end
  end

  assign id_valid_o        = slot.valid;
  assign id_pc_o           = slot.pc;
  assign id_adel_o         = slot.adel;
  assign id_in_delayslot_o = slot.in_delayslot;

  // Bubbles and address-error slots present a zero word.
  assign id_instr_o = (slot.valid && !slot.adel)
                    ? (hold_valid ? hold_instr : sram.inst_sram_rdata)
                    : '0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed plus randomized bench for if_fetch_stage against a fetch-stream model.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall_i, flush_i, branch_taken_i, id_is_branch_i;
  logic [31:0] flush_pc_i, branch_target_i;
  logic        id_valid_o, id_adel_o, id_in_delayslot_o;
  logic [31:0] id_pc_o, id_instr_o;

  if_fetch_stage_if sram();

  if_fetch_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .flush_pc_i        (flush_pc_i),
    .branch_taken_i    (branch_taken_i),
    .branch_target_i   (branch_target_i),
    .id_is_branch_i    (id_is_branch_i),
    .sram              (sram),
    .id_valid_o        (id_valid_o),
    .id_pc_o           (id_pc_o),
    .id_instr_o        (id_instr_o),
    .id_adel_o         (id_adel_o),
    .id_in_delayslot_o (id_in_delayslot_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory content derived from the physical address.
  function automatic logic [31:0] mem_word(input logic [31:0] pa);
    if (pa == 32'h1FC0_000C) return 32'h2401_0001;
    return {~pa[15:0], pa[15:0]} ^ 32'h0F0F_0000;
  endfunction

  function automatic logic [31:0] phys(input logic [31:0] va);
    if (va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) return va - 32'h8000_0000 - (va >= 32'hA000_0000 ? 32'h2000_0000 : 32'h0);
    return va;
  endfunction

  // SRAM: one-cycle read latency; corrupt replaces the bus while decode is stalled.
  logic [31:0] rdata_q = 32'h0;
  logic        corrupt = 1'b0;
  always @(posedge clk) if (sram.inst_sram_en) rdata_q <= mem_word(sram.inst_sram_addr);
  assign sram.inst_sram_rdata = corrupt ? 32'hDEAD_BEEF : rdata_q;

  // Expected stream: next fetch address and the instruction in the decode slot.
  logic [31:0] m_pc, m_spc, m_instr;
  logic        m_valid, m_adel, m_ds, m_held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'hBFC0_0000; m_valid = 1'b0; m_ds = 1'b0; m_held = 1'b0;
    m_spc = 32'h0; m_instr = 32'h0; m_adel = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_en"},    {31'h0, sram.inst_sram_en}, 32'h0);
    chk({tag, "_valid"}, {31'h0, id_valid_o}, 32'h0);
    chk({tag, "_pc"},    id_pc_o, 32'h0);
    chk({tag, "_instr"}, id_instr_o, 32'h0);
    chk({tag, "_adel"},  {31'h0, id_adel_o}, 32'h0);
    chk({tag, "_ds"},    {31'h0, id_in_delayslot_o}, 32'h0);
  endtask

  task automatic check_outputs();
    chk("req_en",   {31'h0, sram.inst_sram_en}, {31'h0, m_pc[1:0] == 2'b00});
    chk("req_addr", sram.inst_sram_addr, phys(m_pc));
    chk("req_wen",  {28'h0, sram.inst_sram_wen}, 32'h0);
    chk("req_wdata", sram.inst_sram_wdata, 32'h0);
    chk("id_valid", {31'h0, id_valid_o}, {31'h0, m_valid});
    chk("id_ds",    {31'h0, id_in_delayslot_o}, {31'h0, m_ds});
    if (m_valid) begin
      chk("id_pc",    id_pc_o, m_spc);
      chk("id_adel",  {31'h0, id_adel_o}, {31'h0, m_adel});
      chk("id_instr", id_instr_o, m_instr);
    end
  endtask

  // One clock: drive, check, then apply the fetch rules at the edge.
  task automatic step(input logic st, input logic fl, input logic [31:0] fpc,
                      input logic bt, input logic [31:0] btg, input logic br);
    stall_i = st; flush_i = fl; flush_pc_i = fpc;
    branch_taken_i = bt; branch_target_i = btg; id_is_branch_i = br;
    corrupt = st && m_held;
    #1;
    check_outputs();
    @(posedge clk);
    if (fl) begin
      m_pc = fpc; m_valid = 1'b0; m_ds = 1'b0; m_held = 1'b0;
    end else if (st) begin
      m_held = 1'b1;
    end else begin
      m_valid = 1'b1;
      m_spc   = m_pc;
      m_adel  = (m_pc % 4) != 0;
      m_instr = m_adel ? 32'h0 : mem_word(phys(m_pc));
      m_ds    = br;
      m_pc    = bt ? btg : m_pc + 32'd4;
      m_held  = 1'b0;
    end
    @(negedge clk);
    corrupt = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  logic        r_st, r_fl, r_bt, r_br;
  logic [31:0] r_fpc, r_tgt;

  initial begin
    resetn = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
    branch_taken_i = 1'b0; branch_target_i = 32'h0; id_is_branch_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset("reset");

    // Sequential fetch from the reset vector.
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("first_req_addr", sram.inst_sram_addr, 32'h1FC0_0000);
    idle(4);
    chk("slot_0c_pc", id_pc_o, 32'hBFC0_000C);
    chk("slot_0c_instr", id_instr_o, 32'h2401_0001);

    // Three stall cycles, bus corrupted after the first.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("stall_hold_instr", id_instr_o, 32'h2401_0001);
    idle(1);
    chk("after_stall_pc", id_pc_o, 32'hBFC0_0010);

    // Taken branch at BFC00010 with delay slot.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0100, 1'b1);
    chk("ds_pc", id_pc_o, 32'hBFC0_0014);
    chk("ds_flag", {31'h0, id_in_delayslot_o}, 32'h1);
    idle(1);
    chk("target_pc", id_pc_o, 32'hBFC0_0100);
    chk("target_ds", {31'h0, id_in_delayslot_o}, 32'h0);
    idle(1);

    // Flush wins over concurrent stall and branch.
    step(1'b1, 1'b1, EXC_VECTOR, 1'b1, 32'h0000_1234, 1'b1);
    chk("flush_bubble", {31'h0, id_valid_o}, 32'h0);
    chk("flush_req_addr", sram.inst_sram_addr, 32'h1FC0_0380);
    idle(1);
    chk("flush_target_pc", id_pc_o, 32'hBFC0_0380);
    idle(1);

    // Misaligned branch target raises a fetch address error after the delay slot.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0102, 1'b1);
    chk("adel_no_req", {31'h0, sram.inst_sram_en}, 32'h0);
    idle(1);
    chk("adel_valid", {31'h0, id_valid_o}, 32'h1);
    chk("adel_flag", {31'h0, id_adel_o}, 32'h1);
    chk("adel_instr", id_instr_o, 32'h0);
    chk("adel_pc", id_pc_o, 32'hBFC0_0102);
    idle(2);
    step(1'b0, 1'b1, EXC_VECTOR, 1'b0, 32'h0, 1'b0);
    idle(2);

    // Randomized traffic, including non-kseg targets and the 32-bit wrap region.
    for (int i = 0; i < 400; i++) begin
      r_st  = $urandom_range(0, 9) < 3;
      r_fl  = (m_pc[1:0] != 2'b00) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      r_fpc = $urandom_range(0, 1) ? EXC_VECTOR : ($urandom & 32'hFFFF_FFFC);
      r_bt  = $urandom_range(0, 5) == 0;
      r_br  = r_bt | ($urandom_range(0, 7) == 0);
      r_tgt = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 : $urandom;
      if ($urandom_range(0, 7) != 0) r_tgt[1:0] = 2'b00;
      step(r_st, r_fl, r_fpc, r_bt, r_tgt, r_br);
    end

    // Asynchronous reset in the middle of a cycle.
    #2;
    resetn = 1'b0;
    #1;
    check_reset("midreset");
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rerun_req_en", {31'h0, sram.inst_sram_en}, 32'h1);
    chk("rerun_req_addr", sram.inst_sram_addr, 32'h1FC0_0000);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
